// File: rtl/key_filter_array.sv
// key_filter_array: multi-channel key debouncer with a shared 1 ms timebase.
// Each channel gives a debounced level (1 = pressed), a press pulse and a
// release pulse. Optional long-press detection is enabled by defining the
// macro KEY_FILTER_LONG_PRESS_EN; without it key_long is tied to 0.
module key_filter_array #(
    parameter int FREQ        = 25_000_000,
    parameter int NUM_KEYS    = 4,
    parameter int DEBOUNCE_MS = 10,
    parameter int ACTIVE_LOW  = 1,
    parameter int LONG_MS     = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int TICK_DIV = FREQ / 1000;
    // A divider of 1 still needs a 1-bit counter so the vector is legal.
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DBC_W    = $clog2(DEBOUNCE_MS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DBC_W-1:0]  DBC_LAST  = DBC_W'(DEBOUNCE_MS - 1);
    localparam logic              IDLE_PIN  = (ACTIVE_LOW != 0);

    // Reject parameter sets the filter cannot honour.
    generate
        if (FREQ < 1000 || NUM_KEYS < 1 || NUM_KEYS > 32 ||
            DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS) begin : g_bad_param
            $error("key_filter_array: illegal parameter combination");
        end
    endgenerate

    logic [TICK_W-1:0]   tick_cnt_reg;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] sync2_reg;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] level_reg;
    logic [NUM_KEYS-1:0] level_d_reg;
    logic [NUM_KEYS-1:0] press_reg;
    logic [NUM_KEYS-1:0] release_reg;

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Free-running millisecond divider; tick is high on its last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    // Two-flop synchroniser; resets to the idle pin level so no false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= {NUM_KEYS{IDLE_PIN}};
            sync2_reg <= {NUM_KEYS{IDLE_PIN}};
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalise polarity: 1 always means pressed.
    assign pressed = sync2_reg ^ {NUM_KEYS{IDLE_PIN}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            logic [DBC_W-1:0] dbc_cnt_reg;
            logic             chan_level_reg;

            // Count ticks while the input disagrees with the level; any
            // agreement restarts the count, so short glitches are discarded.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dbc_cnt_reg    <= '0;
                    chan_level_reg <= 1'b0;
                end else if (pressed[gi] == chan_level_reg) begin
                    dbc_cnt_reg <= '0;
                end else if (tick) begin
                    if (dbc_cnt_reg == DBC_LAST) begin
                        dbc_cnt_reg    <= '0;
                        chan_level_reg <= ~chan_level_reg;
                    end else begin
                        dbc_cnt_reg <= dbc_cnt_reg + DBC_W'(1);
                    end
                end
            end

            assign level_reg[gi] = chan_level_reg;
        end
    endgenerate

    // Edge pulses, one cycle after the debounced level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_reg <= '0;
            press_reg   <= '0;
            release_reg <= '0;
        end else begin
            level_d_reg <= level_reg;
            press_reg   <= level_reg & ~level_d_reg;
            release_reg <= ~level_reg & level_d_reg;
        end
    end

    assign key_level   = level_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;

`ifdef KEY_FILTER_LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(LONG_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);

    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_long
            logic [HOLD_W-1:0] hold_cnt_reg;
            logic              long_done_reg;
            logic              long_reg;

            // Millisecond hold timer, saturating so it cannot wrap mid-press.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt_reg <= '0;
                end else if (!level_reg[gi]) begin
                    hold_cnt_reg <= '0;
                end else if (tick && (hold_cnt_reg != HOLD_MAX)) begin
                    hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                end
            end

            // Single long pulse per press; the done flag blocks auto-repeat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    long_reg      <= 1'b0;
                    long_done_reg <= 1'b0;
                end else if (!level_reg[gi]) begin
                    long_reg      <= 1'b0;
                    long_done_reg <= 1'b0;
                end else if ((hold_cnt_reg == HOLD_MAX) && !long_done_reg) begin
                    long_reg      <= 1'b1;
                    long_done_reg <= 1'b1;
                end else begin
                    long_reg <= 1'b0;
                end
            end

            assign key_long[gi] = long_reg;
        end
    endgenerate
`else
    assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_filter_array.sv
// Testbench for key_filter_array: reset, clean press, bounce rejection,
// simultaneous channels, table of steady-state vectors, mid-operation reset
// and long-press behaviour (or key_long tied low when the feature is off).
module tb_key_filter_array;

    localparam int NK = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = 2'b11;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    key_filter_array #(
        .FREQ        (100_000),
        .NUM_KEYS    (NK),
        .DEBOUNCE_MS (2),
        .ACTIVE_LOW  (1),
        .LONG_MS     (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-window observation accumulators.
    int cyc;
    int press_cnt [NK];
    int rel_cnt   [NK];
    int long_cnt  [NK];
    int lvl_cnt   [NK];
    int overlap_cnt;
    int both_press_cnt;
    int both_rel_cnt;
    int first_press_cyc;
    int first_level_cyc;
    int first_long_cyc;

    typedef struct {
        logic [NK-1:0] key;
        int            cycles;
        logic [NK-1:0] level;
        int            p0;
        int            p1;
        int            r0;
        int            r1;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual < lo || actual > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic clear_acc();
        cyc = 0;
        for (int c = 0; c < NK; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
            long_cnt[c]  = 0;
            lvl_cnt[c]   = 0;
        end
        overlap_cnt     = 0;
        both_press_cnt  = 0;
        both_rel_cnt    = 0;
        first_press_cyc = -1;
        first_level_cyc = -1;
        first_long_cyc  = -1;
    endtask

    // Advance n clocks, sampling outputs 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < NK; c++) begin
                if (key_press[c])   press_cnt[c]++;
                if (key_release[c]) rel_cnt[c]++;
                if (key_long[c])    long_cnt[c]++;
                if (key_level[c])   lvl_cnt[c]++;
                if (key_press[c] && key_release[c]) overlap_cnt++;
            end
            if (key_press == 2'b11)   both_press_cnt++;
            if (key_release == 2'b11) both_rel_cnt++;
            if (key_press[0] && first_press_cyc < 0) first_press_cyc = cyc;
            if (key_level[0] && first_level_cyc < 0) first_level_cyc = cyc;
            if (key_long[0] && first_long_cyc < 0)   first_long_cyc = cyc;
        end
    endtask

    initial begin
        // key_in bit = 0 means pressed (active-low pins)
        vecs[0] = '{key: 2'b00, cycles: 300, level: 2'b11, p0: 1, p1: 1, r0: 0, r1: 0};
        vecs[1] = '{key: 2'b01, cycles: 300, level: 2'b10, p0: 0, p1: 0, r0: 1, r1: 0};
        vecs[2] = '{key: 2'b10, cycles: 300, level: 2'b01, p0: 1, p1: 0, r0: 0, r1: 1};
        vecs[3] = '{key: 2'b11, cycles: 300, level: 2'b00, p0: 0, p1: 0, r0: 1, r1: 0};
        vecs[4] = '{key: 2'b10, cycles: 60,  level: 2'b00, p0: 0, p1: 0, r0: 0, r1: 0};
        vecs[5] = '{key: 2'b11, cycles: 300, level: 2'b00, p0: 0, p1: 0, r0: 0, r1: 0};

        clear_acc();

        // Reset state, asserted with no clock edge yet.
        #2;
        check("reset_level",   int'(key_level),   0);
        check("reset_press",   int'(key_press),   0);
        check("reset_release", int'(key_release), 0);
        check("reset_long",    int'(key_long),    0);
        $display("txn reset: level=%b press=%b release=%b", key_level, key_press, key_release);

        step(3);
        rst_n = 1'b1;
        clear_acc();
        step(200);
        check("idle_level_cycles", lvl_cnt[0] + lvl_cnt[1], 0);
        check("idle_pulses", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1], 0);
        $display("txn idle 200 cycles: level=%b", key_level);

        // Clean press on channel 0.
        clear_acc();
        key_in = 2'b10;
        step(300);
        check_range("press_latency", first_level_cyc, 103, 203);
        check("press_pulse_cycles", press_cnt[0], 1);
        check("press_after_level", first_press_cyc, first_level_cyc + 1);
        check("ch1_untouched", lvl_cnt[1] + press_cnt[1], 0);
        $display("txn clean press: level at %0d, press at %0d", first_level_cyc, first_press_cyc);

        clear_acc();
        key_in = 2'b11;
        step(300);
        check("release_level", int'(key_level), 0);
        check("release_pulse_cycles", rel_cnt[0], 1);
        $display("txn clean release: release pulses=%0d", rel_cnt[0]);

        // Bounce: toggle every 50 cycles for 1000 cycles, settle released.
        clear_acc();
        for (int t = 0; t < 20; t++) begin
            key_in[0] = ~key_in[0];
            step(50);
        end
        key_in = 2'b11;
        step(300);
        check("bounce_level_cycles", lvl_cnt[0], 0);
        check("bounce_press", press_cnt[0], 0);
        check("bounce_release", rel_cnt[0], 0);
        $display("txn bounce: level cycles=%0d press=%0d release=%0d", lvl_cnt[0], press_cnt[0], rel_cnt[0]);

        // Simultaneous press and release of both channels.
        clear_acc();
        key_in = 2'b00;
        step(300);
        check("both_press_cycle", both_press_cnt, 1);
        check("both_level", int'(key_level), 3);
        clear_acc();
        key_in = 2'b11;
        step(300);
        check("both_release_cycle", both_rel_cnt, 1);
        check("both_level_off", int'(key_level), 0);
        $display("txn simultaneous: press-both and release-both observed");

        // Table-driven steady-state vectors.
        for (int v = 0; v < 6; v++) begin
            clear_acc();
            key_in = vecs[v].key;
            step(vecs[v].cycles);
            check($sformatf("vec%0d_level", v), int'(key_level), int'(vecs[v].level));
            check($sformatf("vec%0d_press0", v), press_cnt[0], vecs[v].p0);
            check($sformatf("vec%0d_press1", v), press_cnt[1], vecs[v].p1);
            check($sformatf("vec%0d_rel0", v), rel_cnt[0], vecs[v].r0);
            check($sformatf("vec%0d_rel1", v), rel_cnt[1], vecs[v].r1);
            check($sformatf("vec%0d_overlap", v), overlap_cnt, 0);
            $display("txn vec%0d: key_in=%b level=%b press=%0d/%0d release=%0d/%0d",
                     v, vecs[v].key, key_level, press_cnt[0], press_cnt[1], rel_cnt[0], rel_cnt[1]);
        end

        // Reset while a key is held.
        clear_acc();
        key_in = 2'b10;
        step(150);
        rst_n = 1'b0;
        #1;
        check("midrst_level",   int'(key_level),   0);
        check("midrst_press",   int'(key_press),   0);
        check("midrst_release", int'(key_release), 0);
        step(2);
        rst_n = 1'b1;
        clear_acc();
        step(300);
        check_range("midrst_press_latency", first_press_cyc, 103, 203);
        check("midrst_press_count", press_cnt[0], 1);
        $display("txn mid-op reset: fresh press at %0d", first_press_cyc);
        key_in = 2'b11;
        step(300);

`ifdef KEY_FILTER_LONG_PRESS_EN
        // Long hold: exactly one key_long about 5 ms after the press pulse.
        clear_acc();
        key_in = 2'b10;
        step(1500);
        check("long_pulse_cycles", long_cnt[0], 1);
        check_range("long_delay", first_long_cyc - first_press_cyc, 400, 600);
        key_in = 2'b11;
        step(300);
        $display("txn long hold: long pulses=%0d delay=%0d", long_cnt[0], first_long_cyc - first_press_cyc);

        // Short hold: press seen, no long pulse.
        clear_acc();
        key_in = 2'b10;
        step(300);
        key_in = 2'b11;
        step(300);
        check("short_press_count", press_cnt[0], 1);
        check("short_no_long", long_cnt[0], 0);
        $display("txn short hold: press=%0d long=%0d", press_cnt[0], long_cnt[0]);
`else
        // Feature compiled out: key_long never asserts even on a long hold.
        clear_acc();
        key_in = 2'b10;
        step(1500);
        check("nolong_press_count", press_cnt[0], 1);
        check("nolong_pulses", long_cnt[0] + long_cnt[1], 0);
        key_in = 2'b11;
        step(300);
        $display("txn long hold (feature off): long pulses=%0d", long_cnt[0]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_filter_array.md
Name: key_filter_array

Overview:
- Parametrised multi-channel successor to the single-key debouncer. Filters NUM_KEYS asynchronous mechanical key inputs against a shared 1 ms timebase.
- Per channel it provides a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between board push-buttons and the DDR3 test/control logic, e.g. start-write, start-read and mode-select keys.

Parameters:
- FREQ, 25_000_000: input clock frequency in Hz. Must be ≥ 1000.
- NUM_KEYS, 4: number of independent key channels. Range 1..32.
- DEBOUNCE_MS, 10: required stable time, in ms ticks. Must be ≥ 1.
- ACTIVE_LOW, 1: 1 = key pressed when pin low (idle high); 0 = pressed when pin high.
- LONG_MS, 1000: long-press threshold in ms ticks. Must exceed DEBOUNCE_MS. Used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- key_in, input, NUM_KEYS: raw key pins, asynchronous to clk.
- key_level, output, NUM_KEYS: debounced state, 1 = pressed, regardless of ACTIVE_LOW.
- key_press, output, NUM_KEYS: one-cycle pulse when key_level rises.
- key_release, output, NUM_KEYS: one-cycle pulse when key_level falls.
- key_long, output, NUM_KEYS: one-cycle long-press pulse. Constant 0 when the feature is compiled out; the port always exists.

Behaviour:
- Reset: one clock (clk). Reset is asynchronous and active-low (rst_n); all flops clear on rst_n low with no clock required.
  - Sync flops load the idle pin level (ACTIVE_LOW ? 1 : 0).
  - tick counter = 0.
  - Per-channel counters = 0.
  - key_level, key_press, key_release, key_long = 0.
- Timebase:
  - TICK_DIV = FREQ/1000 (integer division).
  - Free-running counter 0..TICK_DIV-1; tick asserted for one cycle when the counter equals TICK_DIV-1, then it wraps to 0.
  - Counter width $clog2(TICK_DIV). TICK_DIV = 1 gives tick every cycle.
- Synchroniser: two flops per channel. Normalised input p = sync2 XOR ACTIVE_LOW, so p = 1 means pressed.
- Debounce, per channel, independent:
  - p == key_level: dbc_cnt cleared to 0 on that cycle, even mid-count.
  - p != key_level and tick: dbc_cnt increments.
  - p != key_level, tick, and dbc_cnt == DEBOUNCE_MS-1: key_level toggles next cycle and dbc_cnt clears.
  - dbc_cnt width $clog2(DEBOUNCE_MS+1); it never exceeds DEBOUNCE_MS-1.
- Latency: from the last pin edge to the key_level change is within [(DEBOUNCE_MS-1)*TICK_DIV+3, DEBOUNCE_MS*TICK_DIV+3] cycles.
  - Any glitch shorter than (DEBOUNCE_MS-1)*TICK_DIV cycles never changes key_level.
- Event pulses:
  - key_press / key_release are registered and high exactly one cycle, on the cycle after key_level changes.
  - Press and release of one channel never coincide.
  - Different channels may pulse in the same cycle; no arbitration.
- Reset mid-operation: all counters and outputs return to reset values. A key held through reset is re-debounced after release of reset and produces a fresh key_press.

Optional Feature:
- Macro: KEY_FILTER_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_MS+1), cleared while key_level == 0.
  - While key_level == 1 it increments on tick, saturating at LONG_MS.
  - key_long pulses exactly one cycle on the cycle after the count reaches LONG_MS. Only one pulse per press, no auto-repeat.
  - A release before LONG_MS produces no key_long.
- Undefined: no hold counters are synthesised; key_long tied to 0.

Test Plan:
- Reset check: FREQ=100_000, NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_MS=2, rst_n low with key_in=2'b11 -> all outputs 0. Release reset and hold 200 cycles -> still 0.
- Clean press: key_in[0] 1->0 and held -> key_level[0]=1 within 103..203 cycles of the edge; key_press[0]=1 for exactly 1 cycle; key_level[1] unchanged.
- Bounce rejection: key_in[0] toggles every 50 cycles for 1000 cycles, then settles at 1 -> key_level[0] stays 0; no key_press or key_release pulses.
- Release and simultaneity: both keys pressed on the same cycle and released on the same cycle -> key_press=2'b11 in one cycle; later key_release=2'b11 in one cycle; key_level returns to 0.
- Mid-operation reset: key held, rst_n pulsed low at cycle 150 after the press edge -> outputs 0 immediately. After reset release, key_press fires once, 103..203 cycles later.
- Long press (KEY_FILTER_LONG_PRESS_EN, LONG_MS=5): key held 1500 cycles -> exactly one key_long[0] pulse, 500±100 cycles after key_press[0]. A 300-cycle press -> no key_long.
